// File: rtl/fd_divisor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fd_divisor_ctrl
// Description : Push-button front end for the 3-bit clock divider. Synchronises
//               and debounces the up/down buttons, steps the divisor by +/-1
//               per press with hold-to-auto-repeat, and saturates at 1 and
//               2**DIV_BITS-1. div_upd pulses in the first cycle of a new value.
// Revision    : 1.0 - initial release
// ============================================================================
module fd_divisor_ctrl #(
    parameter int DIV_BITS        = 3,
    parameter int DIV_RESET       = 1,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_up,
    input  logic                btn_down,
    output logic [DIV_BITS-1:0] divisor,
    output logic                div_upd
);

    localparam int c_DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_TMR_W   = (c_TMR_MAX > 2) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_TMR_W-1:0]  c_HOLD_LAST = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_REP_LAST  = c_TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [DIV_BITS-1:0] c_DIV_MAX   = '1;
    localparam logic [DIV_BITS-1:0] c_DIV_ONE   = DIV_BITS'(1);
    localparam logic [DIV_BITS-1:0] c_DIV_RST   = DIV_BITS'(DIV_RESET);

    // Button index 0 = up, 1 = down (also the dir encoding)
    logic [1:0] w_raw;
    logic [1:0] w_lvl;
    logic [1:0] w_press;
    logic       r_vld1;
    logic       r_vld2;

    assign w_raw = {btn_down, btn_up};

    // Marks when the sync stages hold real button samples again after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld1 <= 1'b0;
            r_vld2 <= 1'b0;
        end else begin
            r_vld1 <= 1'b1;
            r_vld2 <= r_vld1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic              r_s1;
        logic              r_s2;
        logic              r_lvl;
        logic              r_lvl_q;
        logic              r_arm;
        logic [c_DB_W-1:0] r_cnt;

        // Two-flop sync, debounce counter, press edge history and re-arm flag.
        // A button held through reset must be seen released before it can
        // produce a press again, so r_arm starts low and is set by a genuine
        // (post-reset) low synced sample.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_q <= 1'b0;
                r_arm   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_raw[i];
                r_s2    <= r_s1;
                r_lvl_q <= r_lvl;
                if (r_vld2 && !r_s2) begin
                    r_arm <= 1'b1;
                end
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DB_ONE;
                end
            end
        end

        assign w_lvl[i]   = r_lvl;
        assign w_press[i] = r_lvl & ~r_lvl_q & r_arm;
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic               w_step;
    logic               w_own;
    logic               w_other;

    assign w_own   = w_lvl[r_dir];
    assign w_other = w_lvl[~r_dir];

    // FSM state, direction and hold/repeat timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Next-state logic: decides when a step happens and in which direction
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press[0] && !w_lvl[1]) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = 1'b0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_HOLD;
                end else if (w_press[1] && !w_lvl[0]) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (!w_own || w_other) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == ((r_state == S_HOLD) ? c_HOLD_LAST : c_REP_LAST)) begin
                    w_step      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Saturating divisor update; div_upd only when the value actually moves
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor <= c_DIV_RST;
            div_upd <= 1'b0;
        end else begin
            div_upd <= 1'b0;
            if (w_step) begin
                if (!w_dir_nxt && (divisor != c_DIV_MAX)) begin
                    divisor <= divisor + c_DIV_ONE;
                    div_upd <= 1'b1;
                end else if (w_dir_nxt && (divisor > c_DIV_ONE)) begin
                    divisor <= divisor - c_DIV_ONE;
                    div_upd <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fd_divisor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fd_divisor_ctrl
// Description : Self-checking bench for fd_divisor_ctrl: directed button
//               scenarios followed by random button activity, compared every
//               cycle against a behavioural model of the press/repeat rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fd_divisor_ctrl;

    localparam int c_DIV_BITS = 3;
    localparam int c_DIV_RST  = 1;
    localparam int c_DB       = 4;
    localparam int c_HOLD     = 20;
    localparam int c_REP      = 8;
    localparam int c_DIV_MAX  = 7;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  btn_up = 1'b0;
    logic                  btn_down = 1'b0;
    logic [c_DIV_BITS-1:0] divisor;
    logic                  div_upd;

    always #5 clk = ~clk;

    fd_divisor_ctrl #(
        .DIV_BITS        (c_DIV_BITS),
        .DIV_RESET       (c_DIV_RST),
        .DEBOUNCE_CYCLES (c_DB),
        .HOLD_CYCLES     (c_HOLD),
        .REPEAT_CYCLES   (c_REP)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .divisor  (divisor),
        .div_upd  (div_upd)
    );

    int n_vec = 0;
    int n_err = 0;
    int upd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: state after the most recent rising edge
    bit         m_valid = 1'b0;
    int         m_div;
    int         m_upd;
    int         m_k;        // edges since the last reset edge
    int         m_cyc = 0;  // absolute edge number
    bit         m_lvl[2];
    bit         m_prev[2];
    bit         m_arm[2];
    int         m_run[2];
    int         m_act;      // -1 none, 0 up held, 1 down held
    int         m_t0;       // edge of the accepted press
    bit [1:0]   m_hist[$];  // raw {down,up} sampled at each edge

    task automatic model_edge(input bit u, input bit d, input bit r);
        bit syn[2];
        bit ol[2];
        bit press[2];
        bit step;
        int sdir;
        int el;
        step = 1'b0;
        sdir = 0;
        if (r) begin
            m_div = c_DIV_RST;
            m_upd = 0;
            m_k   = 0;
            m_act = -1;
            m_t0  = 0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b]  = 1'b0;
                m_prev[b] = 1'b0;
                m_arm[b]  = 1'b0;
                m_run[b]  = 0;
            end
        end else begin
            m_k++;
            // Synchronised value = raw from two edges ago, zero while the
            // sync stages still hold their reset value
            for (int b = 0; b < 2; b++) begin
                syn[b]   = (m_k >= 3) ? m_hist[m_hist.size()-2][b] : 1'b0;
                ol[b]    = m_lvl[b];
                press[b] = m_lvl[b] && !m_prev[b] && m_arm[b];
            end
            if (m_act < 0) begin
                if (press[0] && !ol[1]) begin
                    step = 1'b1; sdir = 0; m_act = 0; m_t0 = m_cyc;
                end else if (press[1] && !ol[0]) begin
                    step = 1'b1; sdir = 1; m_act = 1; m_t0 = m_cyc;
                end
            end else if (!ol[m_act] || ol[1-m_act]) begin
                m_act = -1;
            end else begin
                el = m_cyc - m_t0;
                if (el >= c_HOLD && ((el - c_HOLD) % c_REP) == 0) begin
                    step = 1'b1;
                    sdir = m_act;
                end
            end
            m_upd = 0;
            if (step) begin
                if (sdir == 0 && m_div < c_DIV_MAX) begin
                    m_div++; m_upd = 1;
                end else if (sdir == 1 && m_div > 1) begin
                    m_div--; m_upd = 1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                m_prev[b] = ol[b];
                if (syn[b] != ol[b]) begin
                    m_run[b]++;
                    if (m_run[b] == c_DB) begin
                        m_lvl[b] = syn[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                if (m_k >= 3 && !syn[b]) m_arm[b] = 1'b1;
            end
        end
        m_hist.push_back({d, u});
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        m_cyc++;
    endtask

    // Drive inputs for n cycles; model follows each edge, DUT checked on negedge
    task automatic tick(input bit u, input bit d, input bit r, input int n);
        repeat (n) begin
            btn_up   = u;
            btn_down = d;
            rst      = r;
            @(posedge clk);
            model_edge(u, d, r);
            if (r) m_valid = 1'b1;
            @(negedge clk);
            if (m_valid) begin
                check("divisor", divisor, m_div);
                check("div_upd", div_upd, m_upd);
                if (div_upd === 1'b1) upd_seen++;
            end
        end
    endtask

    initial begin
        @(negedge clk);

        // Reset and idle
        tick(0, 0, 1, 3);
        upd_seen = 0;
        tick(0, 0, 0, 10);
        check("reset_div", divisor, 1);
        check("reset_no_upd", upd_seen, 0);

        // Single press, then a short glitch
        upd_seen = 0;
        tick(1, 0, 0, 10);
        tick(0, 0, 0, 15);
        check("press_div", divisor, 2);
        check("press_pulses", upd_seen, 1);
        upd_seen = 0;
        tick(1, 0, 0, 3);
        tick(0, 0, 0, 15);
        check("glitch_div", divisor, 2);
        check("glitch_pulses", upd_seen, 0);

        // Hold up into auto-repeat from 1: steps at +0,+20,+28,+36,+44,+52
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 5);
        upd_seen = 0;
        tick(1, 0, 0, 60);
        tick(0, 0, 0, 40);
        check("repeat_div", divisor, 7);
        check("repeat_pulses", upd_seen, 6);

        // Upper and lower limits
        upd_seen = 0;
        tick(1, 0, 0, 10);
        tick(0, 0, 0, 15);
        check("top_limit_div", divisor, 7);
        check("top_limit_pulses", upd_seen, 0);
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 5);
        upd_seen = 0;
        tick(0, 1, 0, 60);
        tick(0, 0, 0, 15);
        check("bottom_limit_div", divisor, 1);
        check("bottom_limit_pulses", upd_seen, 0);

        // Both buttons together, then second button during HOLD
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 5);
        upd_seen = 0;
        tick(1, 1, 0, 30);
        tick(0, 0, 0, 15);
        check("both_div", divisor, 1);
        check("both_pulses", upd_seen, 0);
        upd_seen = 0;
        tick(1, 0, 0, 10);
        tick(1, 1, 0, 50);
        tick(0, 0, 0, 15);
        check("cancel_div", divisor, 2);
        check("cancel_pulses", upd_seen, 1);

        // Reset during REPEAT with button still held
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 5);
        tick(1, 0, 0, 30);
        check("pre_abort_div", divisor, 3);
        tick(1, 0, 1, 1);
        check("abort_div", divisor, c_DIV_RST);
        upd_seen = 0;
        tick(1, 0, 0, 40);
        check("abort_held_div", divisor, 1);
        check("abort_held_pulses", upd_seen, 0);
        tick(0, 0, 0, 10);
        tick(1, 0, 0, 10);
        tick(0, 0, 0, 10);
        check("repress_div", divisor, 2);

        // Random button activity with occasional resets
        for (int s = 0; s < 80; s++) begin
            bit ru;
            bit rd;
            ru = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                tick(ru, rd, 1, 1);
            end
            tick(ru, rd, 0, $urandom_range(1, 50));
        end
        tick(0, 0, 0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
